// File: rtl/pass_pkg.sv
// Shared definitions for the password store, used by both the writer and the login reader
// so that both agree on the slot layout: four nibbles, most-significant digit at the slot base.
package pass_pkg;
  localparam int PASS_DIGITS = 4;
  localparam int NIBBLE_W    = 4;
  localparam int PASS_W      = PASS_DIGITS * NIBBLE_W;
  localparam int CNT_W       = $clog2(PASS_DIGITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY1,
    ST_ENTRY2,
    ST_COMPARE,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Slot word k holds digit k; digit 0 is the first one typed, in the top nibble.
  function automatic logic [NIBBLE_W-1:0] pass_nibble(input logic [PASS_W-1:0] pass,
                                                      input logic [CNT_W-1:0]  k);
    return pass[(PASS_DIGITS - 1 - int'(k)) * NIBBLE_W +: NIBBLE_W];
  endfunction
endpackage

// File: rtl/pass_digit_shift.sv
// Collects one password entry: shifts digits in at the bottom and flags the last one
// combinationally so the controller can change state on the same edge it is captured.
module pass_digit_shift
  import pass_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                shift,
  input  logic [NIBBLE_W-1:0] digit,
  output logic [PASS_W-1:0]   value,
  output logic                full
);
  logic [CNT_W-1:0] cnt;

  // The counter wraps to zero on the last digit, ready for the next entry.
  assign full = shift && (cnt == CNT_W'(PASS_DIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      cnt   <= '0;
    end else if (clr) begin
      value <= '0;
      cnt   <= '0;
    end else if (shift) begin
      value <= {value[PASS_W-NIBBLE_W-1:0], digit};
      cnt   <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/pass_writer.sv
// Password-change engine: takes the new password twice, and on agreement writes it
// into the user's aligned 4-word RAM slot, most-significant digit first.
module pass_writer
  import pass_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int MAX_TRIES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Start,
  input  logic                Cancel,
  input  logic                Game_Enter,
  input  logic [NIBBLE_W-1:0] User_digit,
  input  logic [ADDR_W-1:0]   Internal_ID,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [NIBBLE_W-1:0] wr_data,
  output logic                Busy,
  output logic                Done,
  output logic                Mismatch,
  output logic                Abort
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_t              state;
  logic [ADDR_W-3:0]   base_hi;
  logic [CNT_W-1:0]    k;
  logic [TRY_W-1:0]    tries;
  logic [PASS_W-1:0]   entry1, entry2;
  logic                full1, full2, clr, same, in_entry;

  assign in_entry = (state == ST_ENTRY1) || (state == ST_ENTRY2) || (state == ST_COMPARE);
  assign same     = (entry1 == entry2);
  // Entries are wiped whenever they can no longer be written, so no secret lingers.
  assign clr = ((state == ST_IDLE) && Start) || (state == ST_DONE) ||
               (in_entry && Cancel) || ((state == ST_COMPARE) && !same);

  pass_digit_shift u_entry1 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .shift ((state == ST_ENTRY1) && Game_Enter && !Cancel),
    .digit (User_digit),
    .value (entry1),
    .full  (full1)
  );

  pass_digit_shift u_entry2 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .shift ((state == ST_ENTRY2) && Game_Enter && !Cancel),
    .digit (User_digit),
    .value (entry2),
    .full  (full2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      base_hi  <= '0;
      k        <= '0;
      tries    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Mismatch <= 1'b0;
      Abort    <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; any branch below may raise one.
      Done     <= 1'b0;
      Mismatch <= 1'b0;
      Abort    <= 1'b0;
      case (state)
        ST_IDLE: if (Start) begin
          base_hi <= Internal_ID[ADDR_W-1:2];
          tries   <= '0;
          Busy    <= 1'b1;
          state   <= ST_ENTRY1;
        end
        ST_ENTRY1, ST_ENTRY2, ST_COMPARE: begin
          if (Cancel) begin
            Abort <= 1'b1;
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (state == ST_ENTRY1) begin
            if (full1) state <= ST_ENTRY2;
          end else if (state == ST_ENTRY2) begin
            if (full2) state <= ST_COMPARE;
          end else if (same) begin
            k       <= '0;
            wr_en   <= 1'b1;
            wr_addr <= {base_hi, 2'd0};
            wr_data <= pass_nibble(entry1, '0);
            state   <= ST_WRITE;
          end else begin
            tries <= tries + TRY_W'(1);
            if (tries == TRY_W'(MAX_TRIES - 1)) begin
              Abort <= 1'b1;
              Busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              Mismatch <= 1'b1;
              state    <= ST_ENTRY1;
            end
          end
        end
        ST_WRITE: begin
          if (k == CNT_W'(PASS_DIGITS - 1)) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            Done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            k       <= k + CNT_W'(1);
            wr_addr <= {base_hi, k + 2'd1};
            wr_data <= pass_nibble(entry1, k + CNT_W'(1));
          end
        end
        ST_DONE: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pass_writer.sv
// Scoreboard bench for pass_writer: expected RAM writes are queued as stimulus is driven
// and popped by a monitor that samples DUT outputs on the falling edge.
module tb_pass_writer;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst, Start, Cancel, Game_Enter;
  logic [3:0]        User_digit;
  logic [ADDR_W-1:0] Internal_ID;
  logic              wr_en, Busy, Done, Mismatch, Abort;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;

  pass_writer #(.ADDR_W(ADDR_W), .MAX_TRIES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .Start      (Start),
    .Cancel     (Cancel),
    .Game_Enter (Game_Enter),
    .User_digit (User_digit),
    .Internal_ID(Internal_ID),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .Busy       (Busy),
    .Done       (Done),
    .Mismatch   (Mismatch),
    .Abort      (Abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, wr_cnt = 0, done_cnt = 0, mism_cnt = 0, abort_cnt = 0, burst_start = 0;
  logic prev_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    cyc++;
    if (!rst) begin
      if (wr_en) begin
        if (!prev_wr) burst_start = cyc;
        wr_cnt++;
        check("wr_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (Done) begin
        done_cnt++;
        check("done_after_wr", cyc - burst_start, 4);
      end
      if (Mismatch) mism_cnt++;
      if (Abort) abort_cnt++;
      if (Done || Mismatch || Abort)
        check("pulse_exclusive", $countones({Done, Mismatch, Abort}), 1);
      prev_wr = wr_en;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] id);
    @(negedge clk);
    Internal_ID = id;
    Start       = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic digit(input logic [3:0] d, input logic cancel = 1'b0);
    @(negedge clk);
    Game_Enter = 1'b1;
    User_digit = d;
    Cancel     = cancel;
    @(negedge clk);
    Game_Enter = 1'b0;
    Cancel     = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] p);
    for (int i = 0; i < 4; i++) digit(p[15-4*i -: 4]);
  endtask

  task automatic push_slot(input logic [ADDR_W-1:0] id, input logic [15:0] p);
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      e.addr = {id[ADDR_W-1:2], 2'b00} + ADDR_W'(i);
      e.data = p[15-4*i -: 4];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
    if (seen) begin
      check({tag, "_busy_in_done"}, 32'(Busy), 1);
      @(negedge clk);
      check({tag, "_busy_fall"}, 32'(Busy), 0);
    end
  endtask

  task automatic wait_wr(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (wr_en) seen = 1'b1;
    end
    check({tag, "_wr_seen"}, 32'(seen), 1);
  endtask

  int wr0, ab0, mi0, dn0;

  initial begin
    rst = 1'b1; Start = 1'b0; Cancel = 1'b0; Game_Enter = 1'b0;
    User_digit = '0; Internal_ID = '0;
    #1;
    check("reset_outputs", 32'({wr_en, wr_addr, wr_data, Busy, Done, Mismatch, Abort}), 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    check("idle_busy", 32'(Busy), 0);

    // Basic write at slot 8.
    push_slot(5'd8, 16'h1234);
    do_start(5'd8);
    check("busy_rise", 32'(Busy), 1);
    enter4(16'h1234);
    enter4(16'h1234);
    wait_done("slot8");
    check("slot8_q_empty", 32'(exp_q.size()), 0);
    check("slot8_wr_cnt", 32'(wr_cnt), 4);

    // Unaligned ID 6 maps to slot 4..7.
    push_slot(5'd6, 16'h90AF);
    do_start(5'd6);
    enter4(16'h90AF);
    enter4(16'h90AF);
    wait_done("slot4");
    check("slot4_q_empty", 32'(exp_q.size()), 0);

    // Three consecutive mismatches: two Mismatch pulses then Abort, no writes.
    wr0 = wr_cnt; ab0 = abort_cnt; mi0 = mism_cnt;
    do_start(5'd3);
    enter4(16'h1234);
    enter4(16'h1235);
    tick(3);
    check("mism1_cnt", 32'(mism_cnt - mi0), 1);
    check("mism1_busy", 32'(Busy), 1);
    enter4(16'h1111);
    enter4(16'h2222);
    tick(3);
    check("mism2_cnt", 32'(mism_cnt - mi0), 2);
    enter4(16'h3333);
    enter4(16'h4444);
    tick(3);
    check("mism3_abort", 32'(abort_cnt - ab0), 1);
    check("mism3_mism_cnt", 32'(mism_cnt - mi0), 2);
    check("mism3_busy", 32'(Busy), 0);
    check("mism_no_writes", 32'(wr_cnt - wr0), 0);

    // Cancel coincident with the last confirm digit.
    ab0 = abort_cnt;
    do_start(5'd12);
    enter4(16'h1234);
    digit(4'h1); digit(4'h2); digit(4'h3);
    digit(4'h4, 1'b1);
    tick(3);
    check("cancel_abort", 32'(abort_cnt - ab0), 1);
    check("cancel_busy", 32'(Busy), 0);
    check("cancel_no_writes", 32'(wr_cnt - wr0), 0);

    // Cancel during WRITE is ignored.
    wr0 = wr_cnt; ab0 = abort_cnt;
    push_slot(5'd12, 16'h5678);
    do_start(5'd12);
    enter4(16'h5678);
    enter4(16'h5678);
    wait_wr("wcancel");
    Cancel = 1'b1;
    tick(2);
    Cancel = 1'b0;
    wait_done("wcancel");
    check("wcancel_writes", 32'(wr_cnt - wr0), 4);
    check("wcancel_no_abort", 32'(abort_cnt - ab0), 0);

    // Reset in the middle of WRITE.
    push_slot(5'd16, 16'h1111);
    do_start(5'd16);
    enter4(16'h1111);
    enter4(16'h1111);
    wait_wr("rstmid");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_outputs", 32'({wr_en, wr_addr, wr_data, Busy, Done, Mismatch, Abort}), 0);
    check("rstmid_pending", 32'(exp_q.size()), 3);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    wr0 = wr_cnt; dn0 = done_cnt;
    enter4(16'h1234);
    tick(3);
    check("post_rst_busy", 32'(Busy), 0);
    check("post_rst_writes", 32'(wr_cnt - wr0), 0);
    check("post_rst_done", 32'(done_cnt - dn0), 0);

    // Start while busy is ignored, including its new ID.
    push_slot(5'd20, 16'h4321);
    do_start(5'd20);
    digit(4'h4);
    do_start(5'd3);
    digit(4'h3); digit(4'h2); digit(4'h1);
    enter4(16'h4321);
    wait_done("busy_start");
    check("busy_start_q_empty", 32'(exp_q.size()), 0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pass_writer.md
# pass_writer

Password-update engine for the MU authentication path, the writing end of the password store that the login controller reads. While a user is logged in, the game controller requests a change. This block then collects a new 4-digit password twice via `Game_Enter`/`User_digit` and compares the two entries. On a match it writes the four nibbles into the password RAM at the user's 4-word slot, most-significant digit first, in the same layout the login path fetches.

## Interface
- `ADDR_W`, 5: password RAM address width.
- `MAX_TRIES`, 3: consecutive confirm mismatches before abort.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Start`  in  1  change request from game controller; sampled only in IDLE.
- `Cancel`  in  1  abort request (e.g. GMLogOut); one-cycle or level.
- `Game_Enter`  in  1  digit strobe; each high cycle captures one digit (debounced upstream).
- `User_digit`  in  4  digit value; any 4-bit value accepted.
- `Internal_ID`  in  ADDR_W  user slot base; latched at Start acceptance.
- `wr_en`  out  1  RAM write enable.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wr_data`  out  4  RAM write nibble.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse after the last write.
- `Mismatch`  out  1  one-cycle pulse per failed confirmation.
- `Abort`  out  1  one-cycle pulse on the MAX_TRIES abort or on Cancel.

## Operation
- States: IDLE → ENTRY1 → ENTRY2 → COMPARE → WRITE → DONE → IDLE.
- IDLE:
  - On `Start`: latch `{Internal_ID[ADDR_W-1:2], 2'b00}` as base, clear the digit count, clear the try count, go to ENTRY1.
  - `Game_Enter` is ignored.
- ENTRY1/ENTRY2:
  - Each `Game_Enter` shifts `User_digit` into a 16-bit register: `reg <= {reg[11:0], digit}`. The first digit ends up in `[15:12]`.
  - After the 4th digit, ENTRY1 goes to ENTRY2, and ENTRY2 goes to COMPARE. The digit count resets on each transition.
- COMPARE, one cycle:
  - If the two entries are equal, go to WRITE with k=0.
  - If they differ: pulse `Mismatch` and increment the try count. If try count+1 == MAX_TRIES, pulse `Abort` and go to IDLE. Otherwise clear both registers and go to ENTRY1.
- WRITE, 4 cycles: `wr_en`=1, `wr_addr`=base+k, `wr_data`=nibble k, where k=0 is `[15:12]` and k=3 is `[3:0]`. After k=3, go to DONE.
- DONE: pulse `Done`, clear both password registers (no stale secret retained), go to IDLE.
- Cancel handling:
  - Cancel in ENTRY1/ENTRY2/COMPARE goes to IDLE with an `Abort` pulse and no writes. This takes priority over a simultaneous `Game_Enter` and over the COMPARE outcome.
  - Cancel during WRITE/DONE is ignored. A slot is never partially written.
- `Start` while Busy is ignored. Changes on `Internal_ID` after latching are ignored.
- Base address ignores `Internal_ID[1:0]`, so the writes always cover one aligned 4-word slot. No address wrap occurs within a slot.

## Timing
- Reset (async, immediate): state IDLE; all outputs 0 (`wr_en`, `wr_addr`, `wr_data`, `Busy`, `Done`, `Mismatch`, `Abort`); registers and counters cleared.
- Reset asserted mid-WRITE deasserts `wr_en` immediately. The partial slot is the upstream controller's responsibility.
- All outputs are registered.
- If the 4th ENTRY2 digit is captured at edge N:
  - COMPARE occupies cycle N+1.
  - `wr_en` is high for cycles N+2..N+5, at addresses base..base+3.
  - `Done` is high in cycle N+6.
  - `Busy` falls at N+7.
- `Start` at edge S: `Busy` is high from cycle S+1.
- `Mismatch`, `Abort` and `Done` are exactly 1 cycle wide and mutually exclusive.

## Structure
- Shared package `pass_pkg`:
  - state enum;
  - `PASS_DIGITS`=4;
  - `NIBBLE_W`=4;
  - `PASS_W`=16.
- The package is also used by the login controller so both ends agree on the slot layout.
- One natural sub-module: `pass_digit_shift`, a 16-bit nibble shift register with a 2-bit digit counter and a `full` flag. It is instantiated twice, once per entry.

## Test plan
- `Internal_ID`=8, Start, enter 1,2,3,4 twice → writes (8,1),(9,2),(10,3),(11,4) on 4 consecutive cycles, then `Done` one cycle after the last write, then IDLE.
- `Internal_ID`=6, entries 9,0,A,F twice → writes to addresses 4..7 with data 9,0,A,F.
- Entries 1234/1235 → `Mismatch` pulse, no `wr_en`, back in ENTRY1. A third consecutive mismatch → `Abort` pulse, IDLE, zero writes total.
- Cancel coincident with the 4th ENTRY2 digit → `Abort`, no writes. Cancel on the 2nd WRITE cycle → all 4 writes complete and `Done` pulses.
- `rst` asserted mid-WRITE → all outputs 0 asynchronously. After release, `Game_Enter` pulses without `Start` produce no activity.
- `Start` pulsed while Busy → ignored. The in-progress sequence completes unchanged.
